// File: rtl/dsp_seq_pkg.sv
// Shared opcode, OPMODE and width definitions for the DSP slice command sequencer.
package dsp_seq_pkg;

  localparam int unsigned AB_W  = 18;
  localparam int unsigned C_W   = 48;
  localparam int unsigned RSP_W = C_W + 2;

  localparam logic [3:0] OP_PADD_MAC_C = 4'd0;
  localparam logic [3:0] OP_PADD_MUL   = 4'd1;
  localparam logic [3:0] OP_PSUB_MUL   = 4'd2;
  localparam logic [3:0] OP_PSUB_MAC_C = 4'd3;
  localparam logic [3:0] OP_MUL        = 4'd4;
  localparam logic [3:0] OP_MAC_C      = 4'd5;
  localparam logic [3:0] OP_PASS_C     = 4'd6;
  localparam logic [3:0] OP_CIN        = 4'd7;
  localparam logic [3:0] OP_PCIN       = 4'd8;
  localparam logic [3:0] OP_ACC        = 4'd9;

  // OPMODE values with the carry-in bit cleared; bit 5 is filled from cmd_cin at issue.
  localparam logic [7:0] OPMODE_IDLE   = 8'h02;
  localparam logic [7:0] OPM_PADD_MAC_C = 8'h1D;
  localparam logic [7:0] OPM_PADD_MUL   = 8'h11;
  localparam logic [7:0] OPM_PSUB_MUL   = 8'h51;
  localparam logic [7:0] OPM_PSUB_MAC_C = 8'h5D;
  localparam logic [7:0] OPM_MUL        = 8'h01;
  localparam logic [7:0] OPM_MAC_C      = 8'h0D;
  localparam logic [7:0] OPM_PASS_C     = 8'h1C;
  localparam logic [7:0] OPM_CIN        = 8'h10;
  localparam logic [7:0] OPM_PCIN       = 8'h14;
  localparam logic [7:0] OPM_ACC        = 8'h12;
  localparam int unsigned OPM_CIN_BIT   = 5;

  typedef struct packed {
    logic           err;
    logic           cout;
    logic [C_W-1:0] p;
  } rsp_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_ACC;
  endfunction

  function automatic logic [7:0] op_opmode(input logic [3:0] op, input logic cin);
    logic [7:0] m;
    case (op)
      OP_PADD_MAC_C: m = OPM_PADD_MAC_C;
      OP_PADD_MUL:   m = OPM_PADD_MUL;
      OP_PSUB_MUL:   m = OPM_PSUB_MUL;
      OP_PSUB_MAC_C: m = OPM_PSUB_MAC_C;
      OP_MUL:        m = OPM_MUL;
      OP_MAC_C:      m = OPM_MAC_C;
      OP_PASS_C:     m = OPM_PASS_C;
      OP_CIN:        m = OPM_CIN;
      OP_PCIN:       m = OPM_PCIN;
      OP_ACC:        m = OPM_ACC;
      default:       m = OPMODE_IDLE;
    endcase
    if (op_is_legal(op)) m[OPM_CIN_BIT] = cin;
    return m;
  endfunction

endpackage

// File: rtl/dsp_rsp_fifo.sv
// Synchronous result FIFO with occupancy count; the head reads as zero while empty.
module dsp_rsp_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && ((count < CNT_W'(DEPTH)) || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dsp_op_sequencer.sv
// Command front-end for a DSP48A1-style slice: decode, registered issue, latency tracking, in-order results.
// Optional DSP_SEQ_PERF_EN adds saturating perf_issued / perf_stall counters.
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DSP_LAT   = 4,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [17:0] cmd_a,
  input  logic [17:0] cmd_b,
  input  logic [17:0] cmd_d,
  input  logic [47:0] cmd_c,
  input  logic        cmd_cin,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [17:0] dsp_d,
  output logic [47:0] dsp_c,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_carryin,
  output logic        dsp_rst,
  input  logic [47:0] dsp_p,
  input  logic        dsp_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [47:0] rsp_p,
  output logic        rsp_cout,
  output logic        rsp_err
`ifdef DSP_SEQ_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic               issue;
  logic               issue_err;
  logic               issued_q;
  logic               issued_err_q;
  logic [DSP_LAT-1:0] tag_v;
  logic [DSP_LAT-1:0] tag_err;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occupancy;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_empty;
  rsp_t               wr_rsp;
  rsp_t               rd_rsp;

  assign dsp_rst = RST;

  // Credit rule: every accepted command owns a FIFO slot from issue until it is popped.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign cmd_ready = occupancy < OCC_W'(RSP_DEPTH);
  assign issue     = cmd_valid && cmd_ready;
  assign issue_err = !op_is_legal(cmd_op);

  always_ff @(posedge CLK) begin
    if (RST || !issue || issue_err) begin
      dsp_a       <= '0;
      dsp_b       <= '0;
      dsp_d       <= '0;
      dsp_c       <= '0;
      dsp_opmode  <= OPMODE_IDLE;
      dsp_carryin <= 1'b0;
    end else begin
      dsp_a       <= cmd_a;
      dsp_b       <= cmd_b;
      dsp_d       <= cmd_d;
      dsp_c       <= cmd_c;
      dsp_opmode  <= op_opmode(cmd_op, cmd_cin);
      dsp_carryin <= cmd_cin;
    end
  end

  // The issue flag plus DSP_LAT tag stages line the result write up with dsp_p validity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issued_q     <= 1'b0;
      issued_err_q <= 1'b0;
      tag_v        <= '0;
      tag_err      <= '0;
    end else begin
      issued_q     <= issue;
      issued_err_q <= issue && issue_err;
      tag_v[0]     <= issued_q;
      tag_err[0]   <= issued_err_q;
      for (int unsigned i = 1; i < DSP_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_err[i] <= tag_err[i-1];
      end
    end
  end

  assign fifo_wr = tag_v[DSP_LAT-1];

  always_comb begin
    wr_rsp = '0;
    if (tag_err[DSP_LAT-1]) begin
      wr_rsp.err = 1'b1;
    end else begin
      wr_rsp.cout = dsp_cout;
      wr_rsp.p    = dsp_p;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= '0;
    end else begin
      case ({issue, fifo_wr})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  dsp_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (fifo_wr),
    .wr_data (wr_rsp),
    .rd_en   (fifo_rd),
    .rd_data (rd_rsp),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign fifo_rd   = rsp_valid && rsp_ready;
  assign rsp_p     = rd_rsp.p;
  assign rsp_cout  = rd_rsp.cout;
  assign rsp_err   = rd_rsp.err;

`ifdef DSP_SEQ_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
      if (cmd_valid && !cmd_ready && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
